n_bit_alu_pipe: RTL and testbench

- Registered, handshaked ALU stage for the N-bit datapath.
- Latches an operand pair and an opcode, then computes MOV/NOT/ADD/SUB/OR/AND/XOR/SLT. SLT is a signed compare with the result zero-extended.
- Buffers results with status flags in a 2-entry output queue, which decouples the producer from the downstream consumer (register-file writeback or test harness).
- Sits directly downstream of the operand source and wraps the combinational set-less-than and arithmetic logic in a sequential, backpressure-aware stage.

---
 rtl/n_bit_alu_pipe.sv | 121 ++++++++++++
 tb/tb_n_bit_alu_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/n_bit_alu_pipe.sv
// Registered ALU stage: accepts an operand pair and an opcode, then buffers each result
// with its status flags in a 2-entry FIFO ahead of the downstream consumer.
module n_bit_alu_pipe #(
  parameter int unsigned Nsize = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [Nsize-1:0] a,
  input  logic [Nsize-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nsize-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic [CNTW-1:0]  op_count
);

  localparam int unsigned EntryW = Nsize + 3;
  localparam int unsigned Msb    = Nsize - 1;

  localparam logic [2:0] OpMov = 3'b000;
  localparam logic [2:0] OpNot = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpAnd = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  logic [EntryW-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [CNTW-1:0]   op_count_q;

  logic [Nsize:0]    sum_w;
  logic [Nsize:0]    diff_w;
  logic              add_ovf;
  logic              sub_ovf;
  logic [Nsize-1:0]  res_d;
  logic              carry_d;
  logic              ovf_d;
  logic [EntryW-1:0] entry_d;
  logic              push;
  logic              pop;

  // Subtraction is a + ~b + 1 so its carry-out doubles as "no borrow".
  assign sum_w   = {1'b0, a} + {1'b0, b};
  assign diff_w  = {1'b0, a} + {1'b0, ~b} + {{Nsize{1'b0}}, 1'b1};
  assign add_ovf = (a[Msb] == b[Msb]) && (sum_w[Msb] != a[Msb]);
  assign sub_ovf = (a[Msb] != b[Msb]) && (diff_w[Msb] != a[Msb]);

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op)
      OpMov: res_d = a;
      OpNot: res_d = ~a;
      OpAdd: begin
        res_d   = sum_w[Nsize-1:0];
        carry_d = sum_w[Nsize];
        ovf_d   = add_ovf;
      end
      OpSub: begin
        res_d   = diff_w[Nsize-1:0];
        carry_d = diff_w[Nsize];
        ovf_d   = sub_ovf;
      end
      OpOr:  res_d = a | b;
      OpAnd: res_d = a & b;
      OpXor: res_d = a ^ b;
      OpSlt: res_d = {{(Nsize-1){1'b0}}, diff_w[Msb] ^ sub_ovf};
      default: res_d = '0;
    endcase
  end

  assign entry_d   = {res_d, (res_d == '0), carry_d, ovf_d};
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      op_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        op_count_q <= op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign {result, zero, carry, ovf} = out_valid ? mem_q[rd_ptr_q] : '0;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_n_bit_alu_pipe.sv
// Directed-vector bench for n_bit_alu_pipe (Nsize=4, CNTW=8).
module tb_n_bit_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       zero;
  logic       carry;
  logic       ovf;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_pass   = 0;

  n_bit_alu_pipe #(
    .Nsize (4),
    .CNTW  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one operation into an empty queue, check the head, then pop it.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [3:0] va,
                       input logic [3:0] vb, input logic [3:0] er, input logic ez,
                       input logic ec, input logic eo);
    op = o; a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, zero, ez);
    check({tag, ".carry"}, carry, ec);
    check({tag, ".ovf"}, ovf, eo);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".drained"}, out_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = 4'h0; b = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.result", result, 0);
    check("rst.flags", {zero, carry, ovf}, 0);
    check("rst.op_count", op_count, 0);

    // Directed ALU vectors
    do_op("slt_neg",  3'b111, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
    do_op("slt_swap", 3'b111, 4'b0111, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0);
    do_op("add_ovf",  3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1);
    do_op("add_cy",   3'b010, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
    do_op("sub_eq",   3'b011, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
    do_op("sub_brw",  3'b011, 4'b0001, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0);
    do_op("mov",      3'b000, 4'b0101, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0);
    do_op("not",      3'b001, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0);
    do_op("or",       3'b100, 4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
    do_op("and",      3'b101, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0);
    do_op("xor",      3'b110, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("vec.op_count", op_count, 11);

    // Backpressure: four offers, only two fit
    do_reset();
    check("bp.rst_count", op_count, 0);
    out_ready = 1'b0;
    op = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      a = i[3:0]; in_valid = 1'b1;
      tick();
      if (i == 1) check("bp.ready_after1", in_ready, 1);
      if (i == 2) check("bp.ready_after2", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp.head0", result, 1);
    out_ready = 1'b1;
    tick();
    check("bp.ready_back", in_ready, 1);
    check("bp.head1", result, 2);
    check("bp.valid1", out_valid, 1);
    tick();
    out_ready = 1'b0;
    check("bp.empty", out_valid, 0);
    check("bp.op_count", op_count, 2);

    // Streaming: ADD a,3 on even cycles, XOR a,3 on odd
    do_reset();
    out_ready = 1'b1;
    b = 4'b0011;
    for (int j = 0; j < 10; j++) begin
      logic [3:0] aj;
      logic [3:0] ej;
      aj = j[3:0];
      ej = (j % 2 == 1) ? (aj ^ 4'b0011) : (aj + 4'b0011);
      op = (j % 2 == 1) ? 3'b110 : 3'b010;
      a = aj; in_valid = 1'b1;
      tick();
      check($sformatf("stream.head%0d", j), result, ej);
      check($sformatf("stream.ready%0d", j), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream.empty", out_valid, 0);
    check("stream.op_count", op_count, 10);

    // Reset with a full queue
    op = 3'b000;
    for (int i = 5; i <= 6; i++) begin
      a = i[3:0]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid.full", in_ready, 0);
    do_reset();
    check("mid.out_valid", out_valid, 0);
    check("mid.in_ready", in_ready, 1);
    check("mid.op_count", op_count, 0);
    check("mid.result", result, 0);
    do_op("mid.new", 3'b000, 4'b1001, 4'b0000, 4'b1001, 1'b0, 1'b0, 1'b0);
    check("mid.op_count_after", op_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
